// File: rtl/spi_slave_mopshub.sv
// SPI mode-0 slave with a one-byte host register file (data, status/control).
// Latency: host read data valid 1 clk after the rd strobe; SPI inputs see SYNC_STAGES+1 clk of sync delay.
// Backpressure: none; an unread rx byte is overwritten and flags overrun, a pending tx byte is overwritten by a host write.
module spi_slave_mopshub #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic [1:0] addr,
    input  logic       wr,
    input  logic       rd,
    input  logic       cs,
    output logic [7:0] out_data,
    input  logic       sclk,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe
);
    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state, state_nxt;
    logic [NS-1:0] sclk_sync, ss_n_sync, mosi_sync;
    logic          sclk_buf, ss_n_buf;
    logic          sclk_s, ss_n_s, mosi_s;
    logic          sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic          frame_start, frame_end, active;
    logic          bit_rise, bit_fall, byte_done, tx_load, tx_shift_en;
    logic          host_wr, host_rd;

    logic [7:0]    tx_shift, rx_shift, tx_buf, rx_data;
    logic [2:0]    bit_cnt;
    logic          tx_full, rx_valid, overrun, reload_pend;

    // Last sync stage vs. one extra delayed copy gives single-cycle edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ss_n_sync <= '1;
            mosi_sync <= '0;
            sclk_buf  <= 1'b0;
            ss_n_buf  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[NS-2:0], sclk};
            ss_n_sync <= {ss_n_sync[NS-2:0], ss_n};
            mosi_sync <= {mosi_sync[NS-2:0], mosi};
            sclk_buf  <= sclk_sync[NS-1];
            ss_n_buf  <= ss_n_sync[NS-1];
        end
    end

    assign sclk_s    = sclk_sync[NS-1];
    assign ss_n_s    = ss_n_sync[NS-1];
    assign mosi_s    = mosi_sync[NS-1];
    assign sclk_rise = sclk_s & ~sclk_buf;
    assign sclk_fall = ~sclk_s & sclk_buf;
    assign ss_fall   = ~ss_n_s & ss_n_buf;
    assign ss_rise   = ss_n_s & ~ss_n_buf;

    assign host_wr = cs & wr;
    assign host_rd = cs & rd & ~wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt   = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A frame ending in the same cycle as an sclk edge wins; the edge is dropped.
    assign active      = (state == ACTIVE);
    assign bit_rise    = active & ~ss_rise & sclk_rise;
    assign bit_fall    = active & ~ss_rise & sclk_fall;
    assign byte_done   = bit_rise & (bit_cnt == 3'd7);
    assign tx_load     = frame_start | (bit_fall & reload_pend);
    assign tx_shift_en = bit_fall & ~reload_pend & (bit_cnt != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            rx_data     <= '0;
        end else begin
            if (tx_load)          tx_shift <= tx_full ? tx_buf : 8'h00;
            else if (tx_shift_en) tx_shift <= {tx_shift[6:0], 1'b0};

            if (frame_start || frame_end) begin
                rx_shift    <= '0;
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end else begin
                if (bit_rise) begin
                    rx_shift <= {rx_shift[6:0], mosi_s};
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done)     reload_pend <= 1'b1;
                else if (bit_fall) reload_pend <= 1'b0;
            end

            if (byte_done) rx_data <= {rx_shift[6:0], mosi_s};
        end
    end

    // Host side: SPI-side set/load events take priority over host clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf   <= '0;
            tx_full  <= 1'b0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            out_data <= '0;
        end else begin
            if (host_wr && addr == 2'b00) begin
                tx_buf  <= in_data;
                tx_full <= 1'b1;
            end else if (tx_load) begin
                tx_full <= 1'b0;
            end

            if (byte_done)                         rx_valid <= 1'b1;
            else if (host_rd && addr == 2'b00)     rx_valid <= 1'b0;

            if (byte_done && rx_valid)                         overrun <= 1'b1;
            else if (host_wr && addr == 2'b01 && in_data[3])   overrun <= 1'b0;

            if (host_rd) begin
                case (addr)
                    2'b00:   out_data <= rx_data;
                    2'b01:   out_data <= {4'b0000, overrun, tx_full, rx_valid, active};
                    default: out_data <= 8'h00;
                endcase
            end
        end
    end

    assign miso    = active & tx_shift[7];
    assign miso_oe = active;

endmodule

// File: tb/tb_spi_slave_mopshub.sv
// Scoreboard bench: stimulus pushes expected host-read bytes and miso bits into queues,
// monitors pop and compare when the DUT presents read data or the master samples miso.
`timescale 1ns/1ps
module tb_spi_slave_mopshub;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic [1:0] addr;
    logic       wr, rd, cs;
    logic [7:0] out_data;
    logic       sclk, ss_n, mosi;
    logic       miso, miso_oe;

    always #5 clk = ~clk;

    spi_slave_mopshub #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .addr(addr), .wr(wr), .rd(rd), .cs(cs),
        .out_data(out_data), .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] host_q[$];
    logic       miso_q[$];
    logic [7:0] master_q[$];

    // Reference model of the register file, updated per transaction.
    logic [7:0] m_tx_buf, m_rx_data;
    logic       m_tx_full, m_rx_valid, m_overrun;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {4'b0000, m_overrun, m_tx_full, m_rx_valid, 1'b0};
    endfunction

    task automatic model_reset();
        m_tx_buf = 8'h00; m_rx_data = 8'h00;
        m_tx_full = 1'b0; m_rx_valid = 1'b0; m_overrun = 1'b0;
    endtask

    // out_data monitor: after a read it must show the queued value, otherwise hold.
    logic [7:0] hold_exp = 8'h00;
    logic       rd_seen;
    always begin
        @(posedge clk);
        rd_seen = rst_n && cs && rd && !wr;
        @(negedge clk);
        if (!rst_n) begin
            hold_exp = 8'h00;
        end else if (rd_seen) begin
            if (host_q.size() == 0) check8("host_q_underflow", 8'h01, 8'h00);
            else hold_exp = host_q.pop_front();
        end
        check8("out_data", out_data, hold_exp);
    end

    // miso monitor: master samples on every sclk rising edge inside a frame.
    always @(posedge sclk) begin
        if (!ss_n && rst_n) begin
            check8("miso_oe_active", {7'b0, miso_oe}, 8'h01);
            if (miso_q.size() == 0) check8("miso_q_underflow", 8'h01, 8'h00);
            else check8("miso_bit", {7'b0, miso}, {7'b0, miso_q.pop_front()});
        end
    end

    task automatic host_write(input logic [1:0] a, input logic [7:0] d, input bit with_rd);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; rd = with_rd; addr = a; in_data = d;
        if (a == 2'b00) begin m_tx_buf = d; m_tx_full = 1'b1; end
        if (a == 2'b01 && d[3]) m_overrun = 1'b0;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] a);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        case (a)
            2'b00: begin host_q.push_back(m_rx_data); m_rx_valid = 1'b0; end
            2'b01: host_q.push_back(m_status());
            default: host_q.push_back(8'h00);
        endcase
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic check_idle_pins(input string tag);
        check8({tag, "_miso"}, {7'b0, miso}, 8'h00);
        check8({tag, "_miso_oe"}, {7'b0, miso_oe}, 8'h00);
    endtask

    // One SPI frame of nbits bits from master_q; optional host read aligned with
    // the last rising edge, or a reset after the last bit instead of ss_n release.
    task automatic spi_frame(input int nbits, input int half, input bit rd_last, input bit rst_mid);
        int nb;
        logic [7:0] t;
        logic [7:0] mb;
        nb = (nbits + 7) / 8;
        for (int k = 0; k < nb; k++) begin
            t = m_tx_full ? m_tx_buf : 8'h00;
            m_tx_full = 1'b0;
            for (int i = 0; i < 8 && i < nbits - 8 * k; i++) miso_q.push_back(t[7-i]);
        end
        @(negedge clk);
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            mb = master_q[b / 8];
            mosi = mb[7 - (b % 8)];
            repeat (half) @(negedge clk);
            sclk = 1'b1;
            if (rd_last && b == nbits - 1) begin
                repeat (2) @(negedge clk);
                cs = 1'b1; rd = 1'b1; addr = 2'b00;
                host_q.push_back(m_rx_data);
                m_rx_valid = 1'b0;
                @(negedge clk);
                cs = 1'b0; rd = 1'b0;
                repeat (half - 3) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            sclk = 1'b0;
            if (b % 8 == 7) begin
                if (m_rx_valid) m_overrun = 1'b1;
                m_rx_data  = mb;
                m_rx_valid = 1'b1;
            end
        end
        if (rst_mid) begin
            #2 rst_n = 1'b0;
            #1;
            check8("rst_out_data", out_data, 8'h00);
            check_idle_pins("rst");
            ss_n = 1'b1; mosi = 1'b0;
            model_reset();
            repeat (3) @(negedge clk);
            #2 rst_n = 1'b1;
        end else begin
            repeat (half) @(negedge clk);
            ss_n = 1'b1;
        end
        repeat (8) @(negedge clk);
        check_idle_pins("post_frame");
        master_q.delete();
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x;
        rst_n = 1'b0;
        cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 2'b00; in_data = 8'h00;
        sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check_idle_pins("reset");
        check8("reset_out_data", out_data, 8'h00);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Loaded tx byte, master sends 0x3C.
        host_write(2'b00, 8'hA5, 1'b0);
        host_read(2'b01);
        master_q.push_back(8'h3C);
        spi_frame(8, 4, 1'b0, 1'b0);
        host_read(2'b01);
        host_read(2'b00);
        host_read(2'b01);

        // Two bytes without a host read -> overrun, then clear it.
        master_q.push_back(8'h11); master_q.push_back(8'h22);
        spi_frame(16, 4, 1'b0, 1'b0);
        host_read(2'b01);
        host_write(2'b01, 8'h08, 1'b0);
        host_read(2'b01);
        host_read(2'b00);

        // No tx byte pending: miso stays low.
        master_q.push_back(8'($urandom));
        spi_frame(8, 5, 1'b0, 1'b0);
        host_read(2'b00);

        // Aborted after 5 bits, then a full frame.
        master_q.push_back(8'($urandom));
        spi_frame(5, 4, 1'b0, 1'b0);
        host_read(2'b01);
        master_q.push_back(8'h5A);
        spi_frame(8, 4, 1'b0, 1'b0);
        host_read(2'b00);

        // Reset after 4 bits, then 0xFF received.
        host_write(2'b00, 8'hFF, 1'b0);
        host_read(2'b01);
        master_q.push_back(8'($urandom));
        spi_frame(4, 4, 1'b0, 1'b1);
        host_read(2'b01);
        master_q.push_back(8'hFF);
        spi_frame(8, 4, 1'b0, 1'b0);
        host_read(2'b00);

        // Host read coinciding with the 8th rising edge.
        host_write(2'b00, 8'($urandom), 1'b0);
        x = 8'($urandom);
        master_q.push_back(x);
        spi_frame(8, 4, 1'b1, 1'b0);
        host_read(2'b01);
        host_read(2'b00);

        // Unmapped addresses, and wr+rd together behaving as a write.
        host_write(2'b10, 8'hFF, 1'b0);
        host_write(2'b11, 8'hFF, 1'b0);
        host_read(2'b10);
        host_read(2'b11);
        host_read(2'b01);
        host_write(2'b00, 8'h96, 1'b1);
        host_read(2'b01);

        // sclk toggling while idle is ignored.
        for (int i = 0; i < 16; i++) begin
            mosi = 1'($urandom);
            repeat (4) @(negedge clk);
            sclk = ~sclk;
        end
        sclk = 1'b0;
        repeat (6) @(negedge clk);
        host_read(2'b01);
        check_idle_pins("idle_sclk");

        // Randomized traffic.
        for (int it = 0; it < 25; it++) begin
            int nbits;
            if ($urandom_range(1, 0) == 1) host_write(2'b00, 8'($urandom), 1'b0);
            nbits = $urandom_range(24, 1);
            for (int k = 0; k < (nbits + 7) / 8; k++) master_q.push_back(8'($urandom));
            spi_frame(nbits, $urandom_range(7, 4), 1'b0, 1'b0);
            host_read(2'b01);
            if ($urandom_range(3, 0) != 0) host_read(2'b00);
            if ($urandom_range(1, 0) == 1) host_write(2'b01, 8'($urandom), 1'b0);
        end

        repeat (4) @(negedge clk);
        check8("miso_q_drained", 8'(miso_q.size()), 8'h00);
        check8("host_q_drained", 8'(host_q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave_mopshub.md
SPI_SLAVE_MOPSHUB -- requirements
Module: spi_slave_mopshub

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, number of synchronizer flops on sclk/ss_n/mosi (minimum 2).
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_data  input  8  host write data.
REQ-005 SHALL have port: addr  input  2  register select: 00 data, 01 status/control.
REQ-006 SHALL have port: wr  input  1  host write strobe, qualified by cs.
REQ-007 SHALL have port: rd  input  1  host read strobe, qualified by cs.
REQ-008 SHALL have port: cs  input  1  host chip select, active-high.
REQ-009 SHALL have port: out_data  output  8  registered host read data.
REQ-010 SHALL have port: sclk  input  1  SPI clock from master, idle low (mode 0).
REQ-011 SHALL have port: ss_n  input  1  SPI slave select, active-low.
REQ-012 SHALL have port: mosi  input  1  serial data from master, MSB first.
REQ-013 SHALL have port: miso  output  1  serial data to master, MSB first.
REQ-014 SHALL have port: miso_oe  output  1  miso drive enable, high while frame active.

Function
REQ-015 SHALL synchronize sclk, ss_n, mosi through SYNC_STAGES flops; edges detected by comparing last synchronized stage with one further delayed copy.
REQ-016 SHALL support sclk up to clk/8; slower sclk unrestricted.
REQ-017 SHALL implement states IDLE and ACTIVE: IDLE->ACTIVE on synced ss_n falling edge; ACTIVE->IDLE on synced ss_n rising edge.
REQ-018 SHALL on IDLE->ACTIVE: load tx shift register from tx_buf if tx_full else 0x00, clear tx_full, bit_cnt=0, miso=shift[7].
REQ-019 SHALL on each synced sclk rising edge in ACTIVE: rx shift <= {rx shift[6:0], mosi_sync}, bit_cnt+1.
REQ-020 SHALL on each synced sclk falling edge in ACTIVE with bit_cnt 1..7: shift tx register left, miso=new bit 7.
REQ-021 SHALL on 8th rising edge: rx_data <= completed byte, rx_valid=1, overrun=1 if rx_valid already 1, bit_cnt=0; next falling edge reloads tx shift per REQ-018 (back-to-back bytes in one frame).
REQ-022 SHALL on ss_n rising edge mid-byte: discard partial byte, bit_cnt=0, no rx_valid, no overrun.
REQ-023 SHALL ignore sclk edges while IDLE; miso=0, miso_oe=0 in IDLE.
REQ-024 SHALL on cs&&wr addr 00: tx_buf <= in_data, tx_full=1 (overwrites pending byte).
REQ-025 SHALL on cs&&wr addr 01: in_data[3]=1 clears overrun; other bits ignored.
REQ-026 SHALL on cs&&rd addr 00: out_data <= rx_data next cycle, rx_valid cleared.
REQ-027 SHALL on cs&&rd addr 01: out_data <= {4'b0, overrun, tx_full, rx_valid, active} next cycle.
REQ-028 SHALL on cs&&rd addr 10/11: out_data <= 0x00; writes there ignored.
REQ-029 SHALL hold out_data when no read; read latency exactly 1 clk.
REQ-030 SHALL give rx_valid set priority over host clear in same cycle; tx load (REQ-018/021) priority over host write to tx_buf in same cycle (host byte then sets tx_full for next byte).
REQ-031 SHALL treat wr and rd asserted together as write only.

Reset
REQ-032 SHALL on rst_n low asynchronously: state IDLE, all shift regs, tx_buf, rx_data, bit_cnt = 0; tx_full, rx_valid, overrun = 0; out_data=0x00; miso=0; miso_oe=0; synchronizer flops ss_n=1, sclk=0, mosi=0.
REQ-033 SHALL on reset during ACTIVE abandon frame; after release wait for new ss_n falling edge.

Verification
REQ-034 SHALL cover: write 0xA5 to addr 00, frame with master sending 0x3C at clk/8 -> miso bits 1,0,1,0,0,1,0,1; status read 0x02 then rx_valid=1; addr 00 read -> 0x3C, status -> 0x00.
REQ-035 SHALL cover: two bytes 0x11, 0x22 in one frame without host read -> rx_data 0x22, overrun=1 (status 0x0A); write 0x08 to addr 01 -> overrun 0.
REQ-036 SHALL cover: no tx_buf write, frame of 8 bits -> miso all 0; rx byte captured correctly.
REQ-037 SHALL cover: ss_n deasserted after 5 bits -> rx_valid stays 0, next full frame 0x5A received intact.
REQ-038 SHALL cover: rst_n asserted after 4 bits -> all outputs 0 within same cycle; next frame 0xFF received correctly.
REQ-039 SHALL cover: host read of addr 00 in same cycle as 8th rising edge -> rx_valid remains 1.
